key_expansion_param: RTL and testbench
======================================

KEY_EXPANSION_PARAM -- requirements
Module: key_expansion_param

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock is the single clock, reset_n is the asynchronous active-low reset.
REQ-002 Parameter MAX_WORDS SHALL default to 60 and set the round-key word storage depth (44 minimum).
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 startTransition  input  1  expansion request, sampled on the rising edge.
REQ-006 keyLen  input  2  key size: 00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = illegal.
REQ-007 roundKeyInput  input  256  cipher key, MSB-aligned; w0 = [255:224]; AES-128 uses [255:128] and AES-192 uses [255:64].
REQ-008 roundIndex  input  4  round-key read address (0..14).
REQ-009 roundKeyOutput  output  128  registered read data {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
REQ-010 busy  output  1  high while expansion is in progress.
REQ-011 done  output  1  one-cycle pulse when the last word has been written.
REQ-012 keyValid  output  1  high while the stored schedule is complete and matches the last accepted key.

Function
REQ-013 Mode parameters SHALL be Nk = 4/6/8, Nr = 10/12/14 and total words T = 4(Nr+1) = 44/52/60 for AES-128/192/256.
REQ-014 The state machine SHALL have exactly two states: IDLE and EXPAND.
REQ-015 In IDLE, startTransition=1 with a legal keyLen SHALL, on that edge: latch keyLen internally; write w0..w(Nk-1) from roundKeyInput; set the word counter to Nk; clear keyValid; set busy; go to EXPAND.
REQ-016 In EXPAND, each edge SHALL write exactly one word w[i] = w[i-Nk] XOR temp, then increment i.
REQ-017 temp SHALL be formed from w[i-1] as follows:
  - i mod Nk = 0: SubWord(RotWord(w[i-1])) XOR {Rcon[i/Nk], 24'h0}.
  - Nk = 8 and i mod Nk = 4: SubWord(w[i-1]).
  - otherwise: w[i-1].
REQ-018 Rcon[1..10] SHALL be 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36; SubWord SHALL apply the FIPS-197 S-box bytewise.
REQ-019 The edge that writes w[T-1] SHALL: set done for exactly one cycle; set keyValid; clear busy; return to IDLE.
REQ-020 Latency from the start-sampling edge to done high SHALL be T-Nk edges: 40, 46 and 52 for AES-128/192/256.
REQ-021 startTransition while busy SHALL be ignored; the latched keyLen and roundKeyInput SHALL have no effect until the next accepted start.
REQ-022 startTransition with keyLen = 11 SHALL be ignored: state, storage and keyValid are unchanged, and no done pulse is produced.
REQ-023 A new accepted start while keyValid=1 SHALL clear keyValid on the start edge and regenerate the whole schedule.
REQ-024 roundKeyOutput SHALL update one edge after roundIndex is presented.
REQ-025 roundKeyOutput SHALL be zero when keyValid=0, or when roundIndex > Nr of the latched mode.

Reset
REQ-026 reset_n=0 SHALL immediately force: state IDLE; busy=0; done=0; keyValid=0; roundKeyOutput=0; word counter 0.
REQ-027 Assertion of reset_n during EXPAND SHALL abort the expansion; no done pulse SHALL follow release.
REQ-028 Word storage contents need not be cleared by reset.
REQ-029 After reset_n deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-030 Macro KEY_EXP_LONGKEY_EN defined: AES-192 and AES-256 SHALL be supported per REQ-013..REQ-025, and storage SHALL be MAX_WORDS words.
REQ-031 Macro KEY_EXP_LONGKEY_EN undefined:
  - Only AES-128 SHALL be supported; keyLen 01 and 10 SHALL be treated as illegal per REQ-022.
  - Storage SHALL be 44 words; the Nk=8 branch and Rcon entries beyond 10 SHALL not be built.
  - roundIndex > 10 SHALL read zero.

Verification
REQ-032 AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> done 40 edges after start; roundIndex=10 reads d014f9a8c9ee2589e13f0cc8b6630ca6; roundIndex=0 reads the key.
REQ-033 AES-192 (macro defined), key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 46 edges; roundIndex=12 reads e98ba06f448c773c8ecc720401002202; roundIndex=13 reads 0.
REQ-034 AES-256 (macro defined), key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 52 edges; roundIndex=14 reads fe4890d1e6188d0b046df344706c631e.
REQ-035 Second start with a different key at edge 10 of an AES-128 run -> ignored; round-10 result still matches REQ-032.
REQ-036 reset_n pulsed low at edge 20 of an expansion -> busy and keyValid drop immediately, no done pulse, roundKeyOutput 0; a fresh start then completes normally.
REQ-037 keyLen=11 with start -> busy stays 0 and keyValid is unchanged; with the macro undefined, keyLen=10 behaves the same.

Source files
------------

// File: rtl/key_expansion_param_if.sv
// ---------------------------------------------------------------------------
// key_expansion_param_if
// Groups the request / read-back signals of the AES key-expansion block.
//
// Signals:
//   startTransition  expansion request, sampled on the rising clock edge
//   keyLen[1:0]      00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = illegal
//   roundKeyInput    256-bit cipher key, MSB-aligned (w0 = [255:224])
//   roundIndex[3:0]  round-key read address
//   roundKeyOutput   registered 128-bit round key {w[4r] .. w[4r+3]}
//   busy             high while the expansion is running
//   done             one-cycle pulse after the last word is written
//   keyValid         stored schedule is complete and matches the last key
//
// Modports:
//   master  requester side (drives request and read address)
//   slave   key-expansion side
// ---------------------------------------------------------------------------
interface key_expansion_param_if;
    logic         startTransition;
    logic [1:0]   keyLen;
    logic [255:0] roundKeyInput;
    logic [3:0]   roundIndex;
    logic [127:0] roundKeyOutput;
    logic         busy;
    logic         done;
    logic         keyValid;

    modport master (
        output startTransition, keyLen, roundKeyInput, roundIndex,
        input  roundKeyOutput, busy, done, keyValid
    );

    modport slave (
        input  startTransition, keyLen, roundKeyInput, roundIndex,
        output roundKeyOutput, busy, done, keyValid
    );
endinterface

// File: rtl/key_expansion_param.sv
// ---------------------------------------------------------------------------
// key_expansion_param
// AES key schedule generator. An accepted start loads the Nk key words,
// then one schedule word is produced per clock until all 4*(Nr+1) words
// are stored. Round keys are read back through a registered port.
//
// Ports:
//   clock    rising-edge clock for all state
//   reset_n  asynchronous active-low reset
//   bus      key_expansion_param_if.slave (request, read-back, status)
//
// Parameters:
//   MAX_WORDS  word storage depth when long keys are built (default 60)
//
// Build option:
//   KEY_EXP_LONGKEY_EN  when defined, AES-192 and AES-256 are supported and
//                       storage is MAX_WORDS words; otherwise only AES-128
//                       is built with 44 words of storage.
// ---------------------------------------------------------------------------
module key_expansion_param #(
    parameter int MAX_WORDS = 60
) (
    input logic                   clock,
    input logic                   reset_n,
    key_expansion_param_if.slave  bus
);

`ifdef KEY_EXP_LONGKEY_EN
    localparam int DEPTH = MAX_WORDS;
`else
    // AES-128 needs only 44 words; smaller values are not legal anyway
    localparam int DEPTH = (MAX_WORDS > 44) ? 44 : MAX_WORDS;
`endif
    localparam int AW = $clog2(DEPTH);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [31:0]     w_mem [DEPTH];
    logic [AW-1:0]   word_cnt;
    logic [2:0]      pos;
    logic [7:0]      rcon;
    logic            done_r;
    logic            key_valid;
    logic [127:0]    rd_data;

    logic            legal;
    logic            load;
    logic            step;
    logic            last;
    logic [AW-1:0]   nk_w;
    logic [2:0]      nk_m1;
    logic [3:0]      nr;
    logic [AW-1:0]   last_idx;
    logic [AW-1:0]   load_nk;
    logic [AW-1:0]   rd_base;
    logic [31:0]     prev_word;
    logic [31:0]     back_word;
    logic [31:0]     temp;
    logic [31:0]     new_word;

    // Mode decode: the running schedule uses the latched mode, while the
    // load step sizes itself from the keyLen presented with the request.
`ifdef KEY_EXP_LONGKEY_EN
    logic [1:0]      mode;

    always_comb begin
        nk_w     = AW'(4);
        nk_m1    = 3'd3;
        nr       = 4'd10;
        last_idx = AW'(43);
        case (mode)
            2'b01: begin
                nk_w     = AW'(6);
                nk_m1    = 3'd5;
                nr       = 4'd12;
                last_idx = AW'(51);
            end
            2'b10: begin
                nk_w     = AW'(8);
                nk_m1    = 3'd7;
                nr       = 4'd14;
                last_idx = AW'(59);
            end
            default: ;
        endcase
    end

    always_comb begin
        load_nk = AW'(4);
        if (bus.keyLen == 2'b01) begin
            load_nk = AW'(6);
        end else if (bus.keyLen == 2'b10) begin
            load_nk = AW'(8);
        end
    end

    assign legal = (bus.keyLen != 2'b11);
`else
    assign nk_w     = AW'(4);
    assign nk_m1    = 3'd3;
    assign nr       = 4'd10;
    assign last_idx = AW'(43);
    assign load_nk  = AW'(4);
    assign legal    = (bus.keyLen == 2'b00);
`endif

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle control strobes
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.startTransition && legal) begin
                    load       = 1'b1;
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
                step = 1'b1;
                if (word_cnt == last_idx) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Next schedule word. pos tracks i mod Nk and rcon tracks Rcon[i/Nk],
    // which avoids any divider on the word counter.
    assign prev_word = w_mem[word_cnt - AW'(1)];
    assign back_word = w_mem[word_cnt - nk_w];

    always_comb begin
        temp = prev_word;
        if (pos == 3'd0) begin
            temp = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h0};
`ifdef KEY_EXP_LONGKEY_EN
        end else if ((nk_w == AW'(8)) && (pos == 3'd4)) begin
            temp = sub_word(prev_word);
`endif
        end
    end

    assign new_word = back_word ^ temp;

    // Counters, status flags and latched mode
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt  <= '0;
            pos       <= 3'd0;
            rcon      <= 8'h01;
            done_r    <= 1'b0;
            key_valid <= 1'b0;
`ifdef KEY_EXP_LONGKEY_EN
            mode      <= 2'b00;
`endif
        end else begin
            done_r <= last;
            if (load) begin
`ifdef KEY_EXP_LONGKEY_EN
                mode      <= bus.keyLen;
`endif
                word_cnt  <= load_nk;
                pos       <= 3'd0;
                rcon      <= 8'h01;
                key_valid <= 1'b0;
            end else if (step) begin
                word_cnt <= word_cnt + AW'(1);
                pos      <= (pos == nk_m1) ? 3'd0 : pos + 3'd1;
                if (pos == 3'd0) begin
                    rcon <= xtime(rcon);
                end
                if (last) begin
                    key_valid <= 1'b1;
                end
            end
        end
    end

    // Word storage; contents survive reset and are rebuilt on each start
    always_ff @(posedge clock) begin
        if (load) begin
            for (int k = 0; k < 8; k++) begin
                if (k < int'(load_nk)) begin
                    w_mem[AW'(k)] <= bus.roundKeyInput[255 - 32*k -: 32];
                end
            end
        end else if (step) begin
            w_mem[word_cnt] <= new_word;
        end
    end

    // Registered read port; cleared together with keyValid on a new start
    assign rd_base = AW'({bus.roundIndex, 2'b00});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (load) begin
            rd_data <= '0;
        end else if (key_valid && (bus.roundIndex <= nr)) begin
            rd_data <= {w_mem[rd_base], w_mem[rd_base + AW'(1)],
                        w_mem[rd_base + AW'(2)], w_mem[rd_base + AW'(3)]};
        end else begin
            rd_data <= '0;
        end
    end

    assign bus.busy           = (state == EXPAND);
    assign bus.done           = done_r;
    assign bus.keyValid       = key_valid;
    assign bus.roundKeyOutput = rd_data;

endmodule

// File: tb/tb_key_expansion_param.sv
// ---------------------------------------------------------------------------
// tb_key_expansion_param
// Self-checking bench for key_expansion_param. The reference schedule is
// computed from the AES rules, with the S-box derived from GF(2^8)
// inversion plus the affine map and Rcon from repeated doubling.
// Honours KEY_EXP_LONGKEY_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_key_expansion_param;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    key_expansion_param_if bus_if ();

    key_expansion_param dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]  sbox_m [256];
    logic [7:0]  rcon_m [11];
    logic [31:0] model_w [60];
    int          model_nr    = 10;
    bit          model_valid = 1'b0;

    localparam logic [127:0] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic buildTables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gfMul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
        rcon_m[0] = 8'h00;
        rcon_m[1] = 8'h01;
        for (int j = 2; j <= 10; j++) rcon_m[j] = gfMul(rcon_m[j-1], 8'h02);
    endtask

    function automatic logic [31:0] subWordM(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    task automatic modelExpand(input logic [1:0] len, input logic [255:0] key);
        int nk;
        int total;
        logic [31:0] t;
        nk       = 4 + 2 * int'(len);
        model_nr = nk + 6;
        total    = 4 * (model_nr + 1);
        for (int i = 0; i < nk; i++) model_w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < total; i++) begin
            t = model_w[i-1];
            if (i % nk == 0) begin
                t = subWordM({t[23:0], t[31:24]}) ^ {rcon_m[i/nk], 24'h0};
            end else if (nk == 8 && i % nk == 4) begin
                t = subWordM(t);
            end
            model_w[i] = model_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] expectedRound(input int r);
        if (model_valid && r <= model_nr)
            return {model_w[4*r], model_w[4*r+1], model_w[4*r+2], model_w[4*r+3]};
        return 128'h0;
    endfunction

    function automatic logic [255:0] randomKey();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [1:0] randomLegalLen();
`ifdef KEY_EXP_LONGKEY_EN
        return 2'($urandom_range(0, 2));
`else
        return 2'b00;
`endif
    endfunction

    // All tasks below start and end just after a falling edge
    task automatic applyStimulus(input logic [1:0] len, input logic [255:0] key);
        bus_if.startTransition = 1'b1;
        bus_if.keyLen          = len;
        bus_if.roundKeyInput   = key;
        @(posedge clock);
        @(negedge clock);
        bus_if.startTransition = 1'b0;
    endtask

    task automatic stepCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic waitDone(input int budget, output int cycles);
        cycles = -1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus_if.done === 1'b1) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic readRound(input int r, output logic [127:0] data);
        bus_if.roundIndex = 4'(r);
        @(posedge clock);
        @(negedge clock);
        data = bus_if.roundKeyOutput;
    endtask

    task automatic runExpansion(input logic [1:0] len, input logic [255:0] key,
                                input string tag);
        int lat;
        int nk;
        nk = 4 + 2 * int'(len);
        applyStimulus(len, key);
        model_valid = 1'b0;
        checkOutput({tag, " busy after start"}, 128'(bus_if.busy), 128'd1);
        checkOutput({tag, " keyValid after start"}, 128'(bus_if.keyValid), 128'd0);
        checkOutput({tag, " output after start"}, bus_if.roundKeyOutput, 128'h0);
        waitDone(100, lat);
        checkOutput({tag, " latency"}, 128'(lat), 128'(4 * (nk + 7) - nk));
        modelExpand(len, key);
        model_valid = 1'b1;
        checkOutput({tag, " keyValid at done"}, 128'(bus_if.keyValid), 128'd1);
        checkOutput({tag, " busy at done"}, 128'(bus_if.busy), 128'd0);
        stepCycles(1);
        checkOutput({tag, " done pulse width"}, 128'(bus_if.done), 128'd0);
    endtask

    task automatic checkAllRounds(input string tag);
        logic [127:0] data;
        for (int r = 0; r < 16; r++) begin
            readRound(r, data);
            checkOutput($sformatf("%s round %0d", tag, r), data, expectedRound(r));
        end
    endtask

    task automatic checkIgnoredStart(input logic [1:0] len, input string tag);
        int done_seen;
        logic [127:0] data;
        bit valid_before;
        valid_before = bus_if.keyValid;
        applyStimulus(len, randomKey());
        checkOutput({tag, " busy"}, 128'(bus_if.busy), 128'd0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus_if.done === 1'b1) done_seen++;
            stepCycles(1);
        end
        checkOutput({tag, " done count"}, 128'(done_seen), 128'd0);
        checkOutput({tag, " keyValid kept"}, 128'(bus_if.keyValid), 128'(valid_before));
        readRound(model_nr, data);
        checkOutput({tag, " last round kept"}, data, expectedRound(model_nr));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] data;
        int lat;
        int done_seen;
        logic [1:0] len;

        bus_if.startTransition = 1'b0;
        bus_if.keyLen          = 2'b00;
        bus_if.roundKeyInput   = '0;
        bus_if.roundIndex      = 4'd0;
        buildTables();

        // Reset state
        @(negedge clock);
        @(negedge clock);
        checkOutput("reset busy", 128'(bus_if.busy), 128'd0);
        checkOutput("reset done", 128'(bus_if.done), 128'd0);
        checkOutput("reset keyValid", 128'(bus_if.keyValid), 128'd0);
        checkOutput("reset output", bus_if.roundKeyOutput, 128'h0);
        reset_n = 1'b1;

        // Known-answer AES-128, started on the first edge after release
        runExpansion(2'b00, {KEY128, 128'h0}, "kat128");
        readRound(10, data);
        checkOutput("kat128 round 10", data, R10_128);
        readRound(0, data);
        checkOutput("kat128 round 0", data, KEY128);
        checkAllRounds("kat128");

`ifdef KEY_EXP_LONGKEY_EN
        runExpansion(2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0},
                     "kat192");
        readRound(12, data);
        checkOutput("kat192 round 12", data, 128'he98ba06f448c773c8ecc720401002202);
        readRound(13, data);
        checkOutput("kat192 round 13", data, 128'h0);

        runExpansion(2'b10,
            256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
            "kat256");
        readRound(14, data);
        checkOutput("kat256 round 14", data, 128'hfe4890d1e6188d0b046df344706c631e);
`endif

        // Illegal key sizes leave a valid schedule untouched
        checkIgnoredStart(2'b11, "illegal11 valid");
`ifndef KEY_EXP_LONGKEY_EN
        checkIgnoredStart(2'b10, "illegal10 valid");
        checkIgnoredStart(2'b01, "illegal01 valid");
`endif

        // Start request during expansion is ignored
        applyStimulus(2'b00, {KEY128, 128'h0});
        model_valid = 1'b0;
        stepCycles(9);
        bus_if.keyLen = randomLegalLen();
        applyStimulus(bus_if.keyLen, randomKey());
        waitDone(100, lat);
        checkOutput("busy start latency", 128'(10 + lat), 128'd40);
        modelExpand(2'b00, {KEY128, 128'h0});
        model_valid = 1'b1;
        stepCycles(1);
        readRound(10, data);
        checkOutput("busy start round 10", data, R10_128);

        // Randomised keys and modes
        for (int it = 0; it < 6; it++) begin
            len = randomLegalLen();
            runExpansion(len, randomKey(), $sformatf("rand%0d", it));
            checkAllRounds($sformatf("rand%0d", it));
        end

        // Reset in the middle of an expansion
        applyStimulus(randomLegalLen(), randomKey());
        model_valid = 1'b0;
        stepCycles(19);
        reset_n = 1'b0;
        #1;
        checkOutput("mid reset busy", 128'(bus_if.busy), 128'd0);
        checkOutput("mid reset keyValid", 128'(bus_if.keyValid), 128'd0);
        checkOutput("mid reset done", 128'(bus_if.done), 128'd0);
        checkOutput("mid reset output", bus_if.roundKeyOutput, 128'h0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 70; i++) begin
            stepCycles(1);
            if (bus_if.done === 1'b1) done_seen++;
        end
        checkOutput("mid reset no done", 128'(done_seen), 128'd0);
        readRound(0, data);
        checkOutput("mid reset read zero", data, 128'h0);

        // Illegal start while no schedule is valid
        checkIgnoredStart(2'b11, "illegal11 invalid");

        // Fresh expansion after the aborted one
        len = randomLegalLen();
        runExpansion(len, randomKey(), "post reset");
        checkAllRounds("post reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
